ahb_mem_bridge: RTL and testbench

Single-master AHB-Lite front end that sits directly downstream of the pipeline's IF and MEM stages and drives the core's AHB master pins. It arbitrates instruction-fetch and data requests, issues one SINGLE transfer at a time, handles HREADY wait states and two-cycle HRESP errors, and returns read data or write completion to the requesting stage. The IF stage consumes if_* responses; the MEM stage consumes dm_* responses.

---
 rtl/ahb_mem_bridge_pkg.sv | 41 ++++
 rtl/ahb_mem_bridge_arb.sv | 38 +++
 rtl/ahb_mem_bridge.sv | 190 +++++++++++++++++++
 tb/tb_ahb_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mem_bridge_pkg.sv
// Shared AHB-Lite constants, FSM state encoding and small helpers for ahb_mem_bridge.
// Only a 32-bit data path is supported, so the helpers are fixed at 32 bits.
package ahb_mem_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_IF_DEFAULT = 4'b0010;
  localparam logic [3:0] HPROT_DM_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Size 3 is not a legal data access size, so it always counts as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_bridge_arb.sv
// Two-way fetch/data request arbiter with a priority pointer.
// Build option ARB_ROUND_ROBIN_EN alternates priority; otherwise data always wins.
module ahb_req_arb
  import ahb_mem_bridge_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_req_if,
  input  logic i_req_dm,
  output logic o_grant_if,
  output logic o_grant_dm,
  output logic o_sel_dm
);

  logic r_prio_dm;
  logic w_sel_dm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_dm <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    end else if (i_en && (i_req_if || i_req_dm)) begin
      // Every grant, misaligned ones included, hands priority to the other side.
      r_prio_dm <= ~w_sel_dm;
`else
    end else begin
      r_prio_dm <= 1'b1;
`endif
    end
  end

  assign w_sel_dm   = i_req_dm & (~i_req_if | r_prio_dm);
  assign o_sel_dm   = w_sel_dm;
  assign o_grant_dm = i_en & w_sel_dm;
  assign o_grant_if = i_en & i_req_if & ~w_sel_dm;

endmodule

// File: rtl/ahb_mem_bridge.sv
// Single-master AHB-Lite bridge serving the IF and MEM stages, one SINGLE transfer at a time.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration (see ahb_req_arb).
module ahb_mem_bridge
  import ahb_mem_bridge_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [3:0] HPROT_IF = HPROT_IF_DEFAULT,
  parameter logic [3:0] HPROT_DM = HPROT_DM_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HWRITE,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_e            r_state, w_state_nxt;
  logic              r_owner_dm, r_flush;
  logic [DATA_W-1:0] r_wdata, r_hwdata;
  logic [ADDR_W-1:0] r_haddr;
  logic [2:0]        r_hsize;
  logic [3:0]        r_hprot;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic              r_if_rvalid, r_if_err, r_dm_rvalid, r_dm_err;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;

  logic w_arb_en, w_grant_if, w_grant_dm, w_sel_dm;
  logic w_dm_mis, w_mis_gnt, w_launch, w_done, w_done_err, w_if_outstanding;

  // Grants are combinational, so they are also gated while reset is held.
  assign w_arb_en = (r_state == ST_IDLE) & reset_n;

  ahb_req_arb u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (w_arb_en),
    .i_req_if   (if_req),
    .i_req_dm   (dm_req),
    .o_grant_if (w_grant_if),
    .o_grant_dm (w_grant_dm),
    .o_sel_dm   (w_sel_dm)
  );

  assign w_dm_mis         = is_misaligned(dm_size, dm_addr[1:0]);
  assign w_mis_gnt        = w_grant_dm & w_dm_mis;
  assign w_launch         = w_grant_if | (w_grant_dm & ~w_dm_mis);
  assign w_if_outstanding = (r_state != ST_IDLE) & ~r_owner_dm;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_ADDR;
      ST_ADDR: if (HREADY) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (HRESP && !HREADY) begin
          w_state_nxt = ST_ERR;
        end else if (HREADY) begin
          // HRESP with HREADY already high breaks the two-cycle rule; finish as an error.
          w_done      = 1'b1;
          w_done_err  = HRESP;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_htrans   <= HTRANS_IDLE;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hsize    <= 3'b000;
      r_hprot    <= 4'b0000;
      r_hwdata   <= '0;
      r_wdata    <= '0;
      r_owner_dm <= 1'b0;
    end else if (w_launch) begin
      r_htrans   <= HTRANS_NONSEQ;
      r_haddr    <= w_sel_dm ? dm_addr : if_addr;
      r_hwrite   <= w_sel_dm & dm_we;
      r_hsize    <= w_sel_dm ? {1'b0, dm_size} : HSIZE_WORD;
      r_hprot    <= w_sel_dm ? HPROT_DM : HPROT_IF;
      r_wdata    <= (w_sel_dm && dm_we) ? dm_wdata : '0;
      r_owner_dm <= w_sel_dm;
    end else if (r_state == ST_ADDR && HREADY) begin
      r_htrans <= HTRANS_IDLE;
      r_hwdata <= lane_replicate(r_hsize[1:0], r_wdata);
    end
  end

  // A flush seen on the completion cycle itself must suppress that response too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_flush <= 1'b0;
    else if (w_done) r_flush <= 1'b0;
    else if (if_flush && (w_grant_if || w_if_outstanding)) r_flush <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_err    <= 1'b0;
      r_dm_rdata  <= '0;
      if (w_mis_gnt) begin
        r_dm_rvalid <= 1'b1;
        r_dm_err    <= 1'b1;
      end else if (w_done && r_owner_dm) begin
        r_dm_rvalid <= 1'b1;
        r_dm_err    <= w_done_err;
        r_dm_rdata  <= (w_done_err || r_hwrite) ? '0 : HRDATA;
      end else if (w_done && !(r_flush || if_flush)) begin
        r_if_rvalid <= 1'b1;
        r_if_err    <= w_done_err;
        r_if_rdata  <= w_done_err ? '0 : HRDATA;
      end
    end
  end

  assign if_gnt    = w_grant_if;
  assign dm_gnt    = w_grant_dm;
  assign if_rvalid = r_if_rvalid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_err    = r_dm_err;
  assign dm_rdata  = r_dm_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign HADDR     = r_haddr;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = r_hprot;
  assign HSIZE     = r_hsize;
  assign HTRANS    = r_htrans;
  assign HWDATA    = r_hwdata;
  assign HWRITE    = r_hwrite;

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Scoreboard bench for ahb_mem_bridge: directed transfers push expected responses,
// an independent monitor pops and compares on every if_rvalid / dm_rvalid pulse.
module tb_ahb_mem_bridge;

  logic        clk, reset_n;
  logic        if_req, if_flush, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        busy, HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb_mem_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_err(dm_err), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        dm;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input logic dm);
    exp_t e;
    if (sb_q.size() == 0) begin
      check(dm ? "unexpected_dm_rsp" : "unexpected_if_rsp", 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      check("rsp_side", 32'(dm), 32'(e.dm));
      check("rsp_cycle", cyc, e.cyc);
      check("rsp_err", 32'(dm ? dm_err : if_err), 32'(e.err));
      check("rsp_rdata", dm ? dm_rdata : if_rdata, e.rdata);
      check("rsp_other_quiet", dm ? (if_rdata | 32'(if_err)) : (dm_rdata | 32'(dm_err)), 32'(0));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (if_rvalid) check_rsp(1'b0);
      if (dm_rvalid) check_rsp(1'b1);
    end
  end

  task automatic wait_gnt(input logic dm, output int g);
    g = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((dm ? dm_gnt : if_gnt) === 1'b1) begin
        g = cyc;
        break;
      end
    end
    if (g < 0) check("gnt_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_xfer(input logic dm, input logic we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] slv_rd, input int waits, input logic err,
                         input logic flush, input logic [31:0] exp_hwdata);
    int g;
    @(posedge clk); #1;
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_size = sz; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_gnt(dm, g);
    if (g < 0) begin
      dm_req = 1'b0; if_req = 1'b0;
      return;
    end
    if (!flush)
      sb_q.push_back('{dm: dm, err: err, rdata: (err || we) ? 32'h0 : slv_rd, cyc: g + 3 + waits});
    @(posedge clk); #1;
    dm_req = 1'b0; if_req = 1'b0; if_flush = flush;
    @(negedge clk);
    check("addr_htrans", 32'(HTRANS), 32'(2'b10));
    check("addr_haddr", HADDR, addr);
    check("addr_hsize", 32'(HSIZE), dm ? {30'b0, sz} : 32'(3'b010));
    check("addr_hprot", 32'(HPROT), dm ? 32'(4'b0011) : 32'(4'b0010));
    check("addr_hwrite", 32'(HWRITE), 32'(dm & we));
    @(posedge clk); #1;
    if_flush = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      HRESP  = err;
      HREADY = (i == waits);
      HRDATA = (i == waits) ? slv_rd : 32'h0;
      @(negedge clk);
      if (i == 0) begin
        check("data_htrans_idle", 32'(HTRANS), 32'(0));
        if (we) check("data_hwdata", HWDATA, exp_hwdata);
      end
      @(posedge clk); #1;
    end
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    @(negedge clk);
    check("xfer_back_idle", 32'(busy), 32'(0));
  endtask

  task automatic do_mis(input logic [1:0] sz, input logic [31:0] addr);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = sz; dm_addr = addr;
    @(negedge clk);
    check("mis_gnt", 32'(dm_gnt), 32'(1));
    sb_q.push_back('{dm: 1'b1, err: 1'b1, rdata: 32'h0, cyc: cyc + 1});
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(negedge clk);
    check("mis_no_bus", 32'(HTRANS), 32'(0));
    check("mis_idle", 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  logic [3:0] arb_exp_dm;
  int         g;
  logic       got_dm;

  initial begin
    reset_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0; dm_addr = '0; dm_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_htrans", 32'(HTRANS), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_haddr", HADDR, 32'h0);
    check("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Fetch, zero wait.
    do_xfer(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 1'b0, 1'b0, 32'h0);
    // Writes: byte with 2 waits, half, word with 1 wait; upper junk must not leak.
    do_xfer(1'b1, 1'b1, 2'd0, 32'h0000_2003, 32'h1234_56A5, 32'h0, 2, 1'b0, 1'b0, 32'hA5A5_A5A5);
    do_xfer(1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'hFFFF_BEEF, 32'h0, 0, 1'b0, 1'b0, 32'hBEEF_BEEF);
    do_xfer(1'b1, 1'b1, 2'd2, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    // Two-cycle slave error on a data read, then on a fetch.
    do_xfer(1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 32'h5555_5555, 1, 1'b1, 1'b0, 32'h0);
    do_xfer(1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h6666_6666, 1, 1'b1, 1'b0, 32'h0);
    // Byte read returns the raw bus word.
    do_xfer(1'b1, 1'b0, 2'd0, 32'h0000_3001, 32'h0, 32'h1122_3344, 0, 1'b0, 1'b0, 32'h0);
    // Misaligned data requests never reach the bus.
    do_mis(2'd2, 32'h0000_1002);
    do_mis(2'd1, 32'h0000_1001);
    do_mis(2'd3, 32'h0000_1000);

    // Contention: both sides held for four grants, from a fresh pointer.
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    arb_exp_dm = 4'b0101;
`else
    arb_exp_dm = 4'b1111;
`endif
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h0000_0300;
    HRDATA = 32'hCAFE_0001;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (if_gnt === 1'b1 || dm_gnt === 1'b1) begin
          g = cyc;
          break;
        end
      end
      if (g < 0) begin
        check("arb_gnt_timeout", 32'(0), 32'(1));
        break;
      end
      got_dm = dm_gnt;
      check("arb_onehot", 32'(if_gnt & dm_gnt), 32'(0));
      check("arb_winner", 32'(got_dm), 32'(arb_exp_dm[k]));
      sb_q.push_back('{dm: arb_exp_dm[k], err: 1'b0, rdata: 32'hCAFE_0001, cyc: g + 3});
      @(posedge clk); #1;
      if (k == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1 HRDATA = 32'h0;

    // Flush one cycle after the grant: bus completes, response dropped; next fetch is normal.
    do_xfer(1'b0, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'h0BAD_0BAD, 0, 1'b0, 1'b1, 32'h0);
    do_xfer(1'b0, 1'b0, 2'd2, 32'h0000_0404, 32'h0, 32'h0000_0013, 0, 1'b0, 1'b0, 32'h0);

    // Reset in the data phase: everything drops at once and no response follows.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd2; dm_addr = 32'h0000_0500; dm_wdata = 32'h1357_9BDF;
    wait_gnt(1'b1, g);
    @(posedge clk); #1;
    dm_req = 1'b0;
    @(posedge clk); #1;
    HREADY = 1'b0;
    @(negedge clk);
    check("rstd_busy_before", 32'(busy), 32'(1));
    #1 reset_n = 1'b0;
    #1;
    check("rstd_htrans", 32'(HTRANS), 32'(0));
    check("rstd_haddr", HADDR, 32'h0);
    check("rstd_hwdata", HWDATA, 32'h0);
    check("rstd_ctrl", {21'b0, HWRITE, HSIZE, HPROT, busy, dm_gnt, if_gnt}, 32'h0);
    @(posedge clk); #1;
    HREADY = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rstd_idle_after", 32'(busy), 32'(0));
    check("sb_drained", sb_q.size(), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
